// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    localparam int unsigned ONEHOT_MAX = 64;

    // Out-of-range selects decode to all-zero so a bad index can never raise a valid.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned sel, input int unsigned n);
        logic [ONEHOT_MAX-1:0] v;
        v = ONEHOT_MAX'(1) << sel;
        if (sel >= n) begin
            v = '0;
        end
        return v;
    endfunction

    function automatic bit sel_fits(input int unsigned sel_w, input int unsigned n_ch);
        return (64'(1) << sel_w) >= 64'(n_ch);
    endfunction

endpackage

// File: rtl/demux_ch_counter.sv
// Saturating per-channel transfer counter; sticks at all-ones instead of wrapping.
module demux_ch_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N valid/ready demultiplexer with a one-word output buffer,
// per-channel transfer counters and sticky bad-select detection.
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [DATA_W-1:0]     in_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [N_CH*CNT_W-1:0] ch_count,
    output logic                  sel_err,
    input  logic                  err_clr
);

    generate
        if (!sel_fits(SEL_W, N_CH) || N_CH < 2 || N_CH > int'(ONEHOT_MAX)) begin : g_bad_params
            $error("demux_1xn_stream: SEL_W too small for N_CH, or N_CH out of range");
        end
    endgenerate

    localparam logic [SEL_W:0] LP_N_CH = (SEL_W+1)'(N_CH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_hold_sel;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_sel_err;
    logic                w_full;
    logic                w_xfer;
    logic                w_accept;
    logic                w_bad;
    logic                w_load;

    assign w_full    = (r_state == ST_FULL);
    assign out_valid = w_full ? N_CH'(onehot(32'(r_hold_sel), N_CH)) : '0;
    assign out_data  = r_hold_data;

    // in_ready is the only path from out_ready; it lets a draining buffer refill in the same cycle.
    assign w_xfer   = |(out_valid & out_ready);
    assign in_ready = !w_full || w_xfer;
    assign w_accept = in_valid && in_ready;
    assign w_bad    = ({1'b0, in_sel} >= LP_N_CH);
    assign w_load   = w_accept && !w_bad;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_load) begin
                    w_state_nxt = ST_FULL;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer keeps its last word while EMPTY; bad-select words never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_sel  <= '0;
            r_hold_data <= '0;
        end else if (w_load) begin
            r_hold_sel  <= in_sel;
            r_hold_data <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_bad) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign sel_err = r_sel_err;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_cnt
            logic [CNT_W-1:0] w_cnt;
            demux_ch_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (out_valid[k] & out_ready[k]),
                .cnt   (w_cnt)
            );
            assign ch_count[k*CNT_W +: CNT_W] = w_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: vector table plus hand sequences on three instances,
// with a scoreboard tracking in-order delivery on the default instance.
module tb_demux_1xn_stream;

    logic clk;
    logic rst_n;

    // Instance A: defaults
    logic        a_in_valid, a_in_ready, a_sel_err, a_err_clr;
    logic [1:0]  a_in_sel;
    logic [7:0]  a_in_data, a_out_data;
    logic [3:0]  a_out_valid, a_out_ready;
    logic [63:0] a_ch_count;

    // Instance B: N_CH=3
    logic        b_in_valid, b_in_ready, b_sel_err, b_err_clr;
    logic [1:0]  b_in_sel;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_out_valid, b_out_ready;
    logic [47:0] b_ch_count;

    // Instance C: CNT_W=4
    logic        c_in_valid, c_in_ready, c_sel_err, c_err_clr;
    logic [1:0]  c_in_sel;
    logic [7:0]  c_in_data, c_out_data;
    logic [3:0]  c_out_valid, c_out_ready;
    logic [15:0] c_ch_count;

    demux_1xn_stream #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sel(a_in_sel), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .ch_count(a_ch_count),
        .sel_err(a_sel_err), .err_clr(a_err_clr)
    );

    demux_1xn_stream #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sel(b_in_sel), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .ch_count(b_ch_count),
        .sel_err(b_sel_err), .err_clr(b_err_clr)
    );

    demux_1xn_stream #(.DATA_W(8), .N_CH(4), .SEL_W(2), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_sel(c_in_sel), .in_data(c_in_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .ch_count(c_ch_count),
        .sel_err(c_sel_err), .err_clr(c_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } sb_t;

    sb_t sb[$];
    sb_t sb_e;
    bit  mon_en = 1'b0;

    // Scoreboard: words pushed on accept, popped on any output transfer of instance A.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if ((a_out_valid & a_out_ready) != 4'b0000) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: got transfer %b expected none", a_out_valid);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_ch", 64'(a_out_valid), 64'(4'b0001 << sb_e.ch));
                    check("sb_data", 64'(a_out_data), 64'(sb_e.data));
                end
            end
            if (a_in_valid && a_in_ready) begin
                sb.push_back('{a_in_sel, a_in_data});
            end
            check("onehot", 64'($countones(a_out_valid) <= 1), 64'(1));
        end
    end

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic [3:0] e_ov;
        logic [7:0] e_od;
        logic       chk_od;
        logic       e_ir;
    } row_t;

    row_t rows[18];

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1;
            a_in_valid  = rows[i].v;
            a_in_sel    = rows[i].sel;
            a_in_data   = rows[i].data;
            a_out_ready = rows[i].ordy;
            @(negedge clk);
            check($sformatf("row%0d_ov", i), 64'(a_out_valid), 64'(rows[i].e_ov));
            check($sformatf("row%0d_ir", i), 64'(a_in_ready), 64'(rows[i].e_ir));
            if (rows[i].chk_od) begin
                check($sformatf("row%0d_od", i), 64'(a_out_data), 64'(rows[i].e_od));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // back-to-back routing with all consumers ready
        rows[0]  = '{1'b1, 2'd0, 8'hA0, 4'b1111, 4'b0000, 8'h00, 1'b0, 1'b1};
        rows[1]  = '{1'b1, 2'd1, 8'hA1, 4'b1111, 4'b0001, 8'hA0, 1'b1, 1'b1};
        rows[2]  = '{1'b1, 2'd2, 8'hA2, 4'b1111, 4'b0010, 8'hA1, 1'b1, 1'b1};
        rows[3]  = '{1'b1, 2'd3, 8'hA3, 4'b1111, 4'b0100, 8'hA2, 1'b1, 1'b1};
        rows[4]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b1000, 8'hA3, 1'b1, 1'b1};
        rows[5]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 8'hA3, 1'b1, 1'b1};
        // backpressure on ch2, second word waits then loads on release
        rows[6]  = '{1'b1, 2'd2, 8'h5A, 4'b0000, 4'b0000, 8'hA3, 1'b1, 1'b1};
        rows[7]  = '{1'b1, 2'd0, 8'hC3, 4'b0000, 4'b0100, 8'h5A, 1'b1, 1'b0};
        rows[8]  = '{1'b1, 2'd0, 8'hC3, 4'b0000, 4'b0100, 8'h5A, 1'b1, 1'b0};
        rows[9]  = '{1'b1, 2'd0, 8'hC3, 4'b0100, 4'b0100, 8'h5A, 1'b1, 1'b1};
        rows[10] = '{1'b0, 2'd0, 8'h00, 4'b0000, 4'b0001, 8'hC3, 1'b1, 1'b0};
        rows[11] = '{1'b0, 2'd0, 8'h00, 4'b0001, 4'b0001, 8'hC3, 1'b1, 1'b1};
        // ch1 stalled: ready on ch3 must not release it
        rows[12] = '{1'b1, 2'd1, 8'h11, 4'b1101, 4'b0000, 8'hC3, 1'b1, 1'b1};
        rows[13] = '{1'b1, 2'd3, 8'h33, 4'b1101, 4'b0010, 8'h11, 1'b1, 1'b0};
        rows[14] = '{1'b1, 2'd3, 8'h33, 4'b1101, 4'b0010, 8'h11, 1'b1, 1'b0};
        rows[15] = '{1'b1, 2'd3, 8'h33, 4'b1111, 4'b0010, 8'h11, 1'b1, 1'b1};
        rows[16] = '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b1000, 8'h33, 1'b1, 1'b1};
        rows[17] = '{1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 8'h33, 1'b1, 1'b1};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_sel = '0; a_in_data = '0; a_out_ready = '0; a_err_clr = 1'b0;
        b_in_valid = 1'b0; b_in_sel = '0; b_in_data = '0; b_out_ready = '0; b_err_clr = 1'b0;
        c_in_valid = 1'b0; c_in_sel = '0; c_in_data = '0; c_out_ready = '0; c_err_clr = 1'b0;
        #22;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ov", 64'(a_out_valid), 64'(0));
        check("rst_od", 64'(a_out_data), 64'(0));
        check("rst_cnt", a_ch_count, 64'(0));
        check("rst_err", 64'(a_sel_err), 64'(0));
        check("rst_ir", 64'(a_in_ready), 64'(1));
        mon_en = 1'b1;

        run_rows(0, 5);
        check("cnt_after_t1", a_ch_count, 64'h0001_0001_0001_0001);
        run_rows(6, 17);
        check("cnt_after_t3", a_ch_count, 64'h0002_0002_0002_0002);

        // async reset while FULL and stalled
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_sel = 2'd1; a_in_data = 8'h77; a_out_ready = 4'b0000;
        @(negedge clk);
        check("t6_ir_pre", 64'(a_in_ready), 64'(1));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t6_ov_full", 64'(a_out_valid), 64'(4'b0010));
        check("t6_ir_full", 64'(a_in_ready), 64'(0));
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_ov_rst", 64'(a_out_valid), 64'(0));
        check("t6_cnt_rst", a_ch_count, 64'(0));
        check("t6_err_rst", 64'(a_sel_err), 64'(0));
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_sel = 2'd2; a_in_data = 8'h9C; a_out_ready = 4'b1111;
        @(negedge clk);
        check("t6_ir_post", 64'(a_in_ready), 64'(1));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t6_ov_post", 64'(a_out_valid), 64'(4'b0100));
        check("t6_od_post", 64'(a_out_data), 64'(8'h9C));
        @(posedge clk);
        @(negedge clk);
        check("t6_cnt_post", a_ch_count, 64'h0000_0001_0000_0000);

        // bad select on the 3-channel instance
        @(posedge clk); #1;
        b_out_ready = 3'b111; b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hFF;
        @(negedge clk);
        check("t4_ir_bad", 64'(b_in_ready), 64'(1));
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("t4_ov_bad", 64'(b_out_valid), 64'(0));
        check("t4_err_set", 64'(b_sel_err), 64'(1));
        @(posedge clk); #1;
        b_err_clr = 1'b1;
        @(posedge clk); #1;
        b_err_clr = 1'b0;
        @(negedge clk);
        check("t4_err_clr", 64'(b_sel_err), 64'(0));
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_sel = 2'd1; b_in_data = 8'h21;
        @(negedge clk);
        check("t4_ir_good", 64'(b_in_ready), 64'(1));
        @(posedge clk); #1;
        b_in_sel = 2'd3; b_in_data = 8'hEE;
        @(negedge clk);
        check("t4_ov_drain", 64'(b_out_valid), 64'(3'b010));
        check("t4_od_drain", 64'(b_out_data), 64'(8'h21));
        check("t4_ir_drain", 64'(b_in_ready), 64'(1));
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("t4_ov_empty", 64'(b_out_valid), 64'(0));
        check("t4_err_drain", 64'(b_sel_err), 64'(1));
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_err_clr = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_err_clr = 1'b0;
        @(negedge clk);
        check("t4_set_beats_clr", 64'(b_sel_err), 64'(1));
        @(posedge clk); #1;
        b_err_clr = 1'b1;
        @(posedge clk); #1;
        b_err_clr = 1'b0;
        @(negedge clk);
        check("t4_err_clr2", 64'(b_sel_err), 64'(0));
        check("t4_cnt", 64'(b_ch_count), 64'h0000_0001_0000);

        // saturation of a 4-bit counter
        @(posedge clk); #1;
        c_out_ready = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            c_in_valid = 1'b1; c_in_sel = 2'd0; c_in_data = 8'(i);
            @(posedge clk); #1;
        end
        c_in_valid = 1'b0;
        @(negedge clk);
        check("t5_ov_last", 64'(c_out_valid), 64'(4'b0001));
        @(posedge clk);
        @(negedge clk);
        check("t5_sat", 64'(c_ch_count), 64'h000F);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
